dac_frame_seq: RTL and testbench
================================

Name: dac_frame_seq

Overview:
- Parametrised multi-channel DAC sample sequencer: one shared interleaved FIFO, a programmable sample-rate divider, and a frame-load FSM.
- Each sample tick pops one frame of CH words (channel 0 first) and loads all CH DAC code registers on the same edge.
- A single-cycle load strobe drives the analog DAC cells' latch/RST inputs.
- Sits between the bus-side register wrapper and CH DAC macros.

Parameters:
- DW, 10, DAC code width per channel.
- CH, 2, channel count (1..8).
- FIFO_AW, 5, FIFO address width; depth = 2**FIFO_AW words, must be >= CH.
- CLKDIV_W, 20, divider width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- en  in  1  block enable.
- clk_en  in  1  divider count enable (gated with en).
- clkdiv  in  CLKDIV_W  tick period minus 1; must be >= CH+1.
- data  in  DW  FIFO write data.
- wr  in  1  FIFO write strobe, one word per cycle.
- flush  in  1  synchronous FIFO clear/frame abort.
- fifo_threshold  in  FIFO_AW+1  low-watermark.
- flags_clr  in  1  clears sticky flags.
- dac_data  out  CH*DW  channel codes; channel k at [k*DW +: DW].
- dac_ld  out  1  load strobe to all DAC cells.
- level  out  FIFO_AW+1  FIFO occupancy, 0..2**FIFO_AW.
- empty  out  1  level==0.
- full  out  1  level==2**FIFO_AW.
- low  out  1  level < fifo_threshold.
- underrun  out  1  sticky: tick found fewer than CH words.
- overflow  out  1  sticky: write attempted while full.

Behaviour:
- Reset (asynchronous, active-low): clk is the single clock; rst_n is asynchronous and active-low. All outputs 0 except empty=1; low = (0 < fifo_threshold). FIFO pointers, divider counter and FSM are cleared.
- Divider:
  - ctr increments when en&clk_en.
  - When ctr==clkdiv, ctr goes to 0 and the registered tick pulses high for one cycle, giving a period of clkdiv+1 cycles.
  - en=0 clears ctr and suppresses tick.
- FIFO:
  - Write accepted when wr & ~full & ~flush.
  - wr while full drops the word and sets overflow.
  - Simultaneous push and pop leaves level unchanged.
  - Pointers wrap modulo depth.
  - level is FIFO_AW+1 bits so the full state is represented exactly.
- FSM states IDLE, RD, LD:
  - IDLE: on tick, if level>=CH go to RD with idx=0; else set underrun, stay in IDLE, and hold dac_data (no dac_ld).
  - RD: pop asserted each cycle; shadow[idx] <= head word; idx++. When idx==CH-1, go to LD and copy the full frame (shadow plus current word) into dac_data on that edge.
  - LD: dac_ld=1 for exactly one cycle, then IDLE.
- Latency: tick at cycle T; pops at T+1..T+CH; dac_data changes and dac_ld is high in cycle T+CH+1.
- Ticks arriving in RD/LD are ignored; with clkdiv >= CH+1 this cannot occur.
- en deasserted mid-frame: the current frame completes (atomic); no further ticks.
- flush:
  - Empties the FIFO next cycle.
  - In RD it aborts to IDLE without dac_ld; dac_data keeps the prior frame.
  - A wr in the same cycle as flush is discarded.
- flags_clr clears underrun/overflow; a set event in the same cycle wins.
- Channel alignment is by pop count only. Software must write whole frames, and flush restores alignment.

Optional Feature:
- DAC_FRAME_SEQ_TWOS_COMP_EN
- Defined: FIFO words are two's complement; the MSB of each word is inverted when copied into dac_data (offset binary to the DAC). E.g. DW=10, 10'h200 -> 10'h000, 10'h000 -> 10'h200.
- Undefined: words pass straight through unchanged.

Test Plan:
- CH=2, clkdiv=9, write 0x011,0x022,0x033,0x044, en=clk_en=1 -> dac_ld pulses every 10 cycles. Frame1 ch0=0x011, ch1=0x022; frame2 0x033/0x044; dac_ld high exactly 3 cycles after tick. Third tick sets underrun and dac_data holds 0x033/0x044.
- Write 1 word (CH=2), tick -> underrun=1, no pop, level stays 1. flags_clr -> underrun=0.
- FIFO_AW=2, write 5 words -> full=1 after 4, level=4, overflow=1, 5th word never appears on dac_data.
- fifo_threshold=3, writes up to level 3 -> low=1 at levels 0..2, low=0 at 3. Simultaneous wr+pop keeps level constant.
- flush asserted in the cycle after the first RD pop -> no dac_ld, dac_data unchanged, level=0, next frame written lands aligned on ch0.
- rst_n low mid-RD -> all outputs reset immediately (async). With TWOS_COMP_EN, writing 0x3FF/0x200 -> dac_data 0x1FF/0x000.

Source files
------------

// File: rtl/dac_frame_seq.sv
// Multi-channel DAC frame sequencer: shared interleaved FIFO, sample-rate divider and frame-load FSM.
// Optional build macro DAC_FRAME_SEQ_TWOS_COMP_EN converts two's-complement words to offset binary on load.
module dac_frame_seq #(
    parameter int DW       = 10,
    parameter int CH       = 2,
    parameter int FIFO_AW  = 5,
    parameter int CLKDIV_W = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clk_en,
    input  logic [CLKDIV_W-1:0]   clkdiv,
    input  logic [DW-1:0]         data,
    input  logic                  wr,
    input  logic                  flush,
    input  logic [FIFO_AW:0]      fifo_threshold,
    input  logic                  flags_clr,
    output logic [CH*DW-1:0]      dac_data,
    output logic                  dac_ld,
    output logic [FIFO_AW:0]      level,
    output logic                  empty,
    output logic                  full,
    output logic                  low,
    output logic                  underrun,
    output logic                  overflow
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int IDX_W = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [FIFO_AW:0] LVL_CH   = (FIFO_AW + 1)'(CH);
    localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_LD
    } state_t;

    function automatic logic [DW-1:0] to_dac(input logic [DW-1:0] w);
        logic [DW-1:0] msb;
        msb         = '0;
        msb[DW-1]   = 1'b1;
`ifdef DAC_FRAME_SEQ_TWOS_COMP_EN
        return w ^ msb;
`else
        return w | (msb & '0);
`endif
    endfunction

    // ------------------------------------------------------------------
    // Sample-rate divider
    // ------------------------------------------------------------------
    logic [CLKDIV_W-1:0] ctr_q, ctr_d;
    logic                tick_q, tick_d;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        ctr_d  = ctr_q;
        tick_d = 1'b0;
        if (!en) begin
            ctr_d = '0;
        end else if (clk_en) begin
            if (ctr_q == clkdiv) begin
                ctr_d  = '0;
                tick_d = 1'b1;
            end else begin
                ctr_d = ctr_q + CLKDIV_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Shared FIFO
    // ------------------------------------------------------------------
    logic [DW-1:0]      mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   level_q, level_d;
    logic               full_w;
    logic               push;
    logic               pop;
    logic [DW-1:0]      head;

    state_t state_q, state_d;

    assign full_w = (level_q == LVL_FULL);
    assign push   = wr & ~full_w & ~flush;
    assign pop    = (state_q == ST_RD) & ~flush;
    assign head   = mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + (FIFO_AW + 1)'(1);
                2'b01:   level_d = level_q - (FIFO_AW + 1)'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // NOTE: storage array has no reset; words are only ever read behind the write pointer.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= data;
    end

    // ------------------------------------------------------------------
    // Frame-load FSM
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CH*DW-1:0] shadow_q, shadow_d;
    logic [CH*DW-1:0] dac_data_q, dac_data_d;
    logic             dac_ld_q, dac_ld_d;
    logic             underrun_q, underrun_d;
    logic             overflow_q, overflow_d;
    logic             tick_en;
    logic             underrun_set;

    assign tick_en = tick_q & en;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        dac_data_d   = dac_data_q;
        underrun_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A tick colliding with flush is treated as part of the abort.
                if (tick_en && !flush) begin
                    if (level_q >= LVL_CH) begin
                        state_d = ST_RD;
                        idx_d   = '0;
                    end else begin
                        underrun_set = 1'b1;
                    end
                end
            end
            ST_RD: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    shadow_d[idx_q*DW +: DW] = head;
                    idx_d                    = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_LD;
                        for (int k = 0; k < CH - 1; k++) begin
                            dac_data_d[k*DW +: DW] = to_dac(shadow_q[k*DW +: DW]);
                        end
                        dac_data_d[(CH-1)*DW +: DW] = to_dac(head);
                    end
                end
            end
            ST_LD:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign dac_ld_d   = (state_d == ST_LD);
    assign underrun_d = underrun_set | (underrun_q & ~flags_clr);
    assign overflow_d = (wr & full_w) | (overflow_q & ~flags_clr);

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr_q      <= '0;
            tick_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            shadow_q   <= '0;
            dac_data_q <= '0;
            dac_ld_q   <= 1'b0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            ctr_q      <= ctr_d;
            tick_q     <= tick_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            dac_data_q <= dac_data_d;
            dac_ld_q   <= dac_ld_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
        end
    end

    assign dac_data = dac_data_q;
    assign dac_ld   = dac_ld_q;
    assign level    = level_q;
    assign empty    = (level_q == '0);
    assign full     = full_w;
    assign low      = (level_q < fifo_threshold);
    assign underrun = underrun_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_dac_frame_seq.sv
// Self-checking bench for dac_frame_seq: directed steps plus random traffic against a queue-based model.
module tb_dac_frame_seq;

    localparam int DW       = 10;
    localparam int CH       = 2;
    localparam int FIFO_AW  = 2;
    localparam int CLKDIV_W = 20;
    localparam int DEPTH    = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                en;
    logic                clk_en;
    logic [CLKDIV_W-1:0] clkdiv;
    logic [DW-1:0]       data;
    logic                wr;
    logic                flush;
    logic [FIFO_AW:0]    fifo_threshold;
    logic                flags_clr;
    logic [CH*DW-1:0]    dac_data;
    logic                dac_ld;
    logic [FIFO_AW:0]    level;
    logic                empty;
    logic                full;
    logic                low;
    logic                underrun;
    logic                overflow;

    dac_frame_seq #(
        .DW(DW), .CH(CH), .FIFO_AW(FIFO_AW), .CLKDIV_W(CLKDIV_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clk_en(clk_en), .clkdiv(clkdiv),
        .data(data), .wr(wr), .flush(flush), .fifo_threshold(fifo_threshold),
        .flags_clr(flags_clr), .dac_data(dac_data), .dac_ld(dac_ld), .level(level),
        .empty(empty), .full(full), .low(low), .underrun(underrun), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: FIFO as a queue, frame as a list of popped words.
    logic [DW-1:0]    m_q[$];
    logic [DW-1:0]    m_frame[$];
    int               m_ctr;
    bit               m_tick;
    int               m_pops_left;
    bit               m_ld;
    logic [CH*DW-1:0] m_dac;
    bit               m_under;
    bit               m_over;

    function automatic logic [DW-1:0] conv(input logic [DW-1:0] w);
`ifdef DAC_FRAME_SEQ_TWOS_COMP_EN
        return w ^ 10'h200;
`else
        return w;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_frame.delete();
        m_ctr       = 0;
        m_tick      = 0;
        m_pops_left = 0;
        m_ld        = 0;
        m_dac       = '0;
        m_under     = 0;
        m_over      = 0;
    endtask

    // Advances the model across one rising edge using the inputs present before it.
    task automatic model_edge();
        int  size_before = m_q.size();
        bit  full_now    = (m_q.size() == DEPTH);
        bit  idle_now    = (m_pops_left == 0) && !m_ld;
        bit  tick_now    = m_tick && en;
        bit  pop_now     = (m_pops_left > 0) && !flush;
        bit  push_now    = wr && !full_now && !flush;
        bit  under_set   = 0;
        bit  ld_next     = 0;
        int  pops_next   = m_pops_left;
        bit  tick_next   = en && clk_en && (m_ctr == clkdiv);

        if (!en)          m_ctr = 0;
        else if (clk_en)  m_ctr = (m_ctr == clkdiv) ? 0 : m_ctr + 1;
        m_tick = tick_next;

        if (flush) begin
            m_q.delete();
            m_frame.delete();
            pops_next = 0;
        end else begin
            if (pop_now) begin
                m_frame.push_back(m_q.pop_front());
                pops_next = m_pops_left - 1;
                if (pops_next == 0) begin
                    for (int k = 0; k < CH; k++) m_dac[k*DW +: DW] = conv(m_frame[k]);
                    m_frame.delete();
                    ld_next = 1;
                end
            end
            if (push_now) m_q.push_back(data);
        end

        if (tick_now && idle_now && !flush) begin
            if (size_before >= CH) pops_next = CH;
            else                   under_set = 1;
        end

        m_pops_left = pops_next;
        m_ld        = ld_next;
        m_under     = under_set | (m_under & !flags_clr);
        m_over      = (wr && full_now) | (m_over & !flags_clr);
    endtask

    task automatic check_all();
        chk("dac_data", dac_data, m_dac);
        chk("dac_ld", dac_ld, m_ld);
        chk("level", level, m_q.size());
        chk("empty", empty, m_q.size() == 0);
        chk("full", full, m_q.size() == DEPTH);
        chk("low", low, m_q.size() < fifo_threshold);
        chk("underrun", underrun, m_under);
        chk("overflow", overflow, m_over);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            check_all();
        end
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        wr   = 1'b1;
        data = w;
        step(1);
        wr   = 1'b0;
    endtask

    // Steps until the model reaches the requested phase; a timeout counts as a failure.
    task automatic wait_phase(input bit want_ld, input int pops_target, input string tag);
        bit hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            step(1);
            if (want_ld ? m_ld : (m_pops_left == pops_target)) hit = 1;
        end
        checks++;
        assert (hit === 1'b1) else begin
            failures++;
            $error("FAIL %s observed=timeout expected=phase_reached", tag);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [CH*DW-1:0] prev;
        int n_ld, ld_c1, ld_c2, lvl0;

        rst_n = 1'b0; en = 0; clk_en = 0; clkdiv = 20'd9; data = '0; wr = 0;
        flush = 0; fifo_threshold = 3'd2; flags_clr = 0;
        model_reset();
        #12;
        check_all();
        rst_n = 1'b1;

        // Two full frames then an underrun tick.
        push_word(10'h011); push_word(10'h022); push_word(10'h033); push_word(10'h044);
        en = 1; clk_en = 1;
        n_ld = 0; ld_c1 = -1; ld_c2 = -1;
        for (int c = 1; c <= 32; c++) begin
            step(1);
            if (dac_ld) begin
                n_ld++;
                if (ld_c1 < 0) ld_c1 = c; else ld_c2 = c;
            end
            if (c == 13) chk("frame1", dac_data, {conv(10'h022), conv(10'h011)});
        end
        chk("ld_count", n_ld, 2);
        chk("first_ld_cycle", ld_c1, 13);
        chk("ld_period", ld_c2 - ld_c1, 10);
        chk("underrun_t1", underrun, 1);
        chk("hold_frame2", dac_data, {conv(10'h044), conv(10'h033)});

        // Single word: tick underruns without popping.
        en = 0; flags_clr = 1; step(1); flags_clr = 0;
        push_word(10'h155);
        en = 1; step(12);
        chk("under_single", underrun, 1);
        chk("level_single", level, 1);
        flags_clr = 1; step(1); flags_clr = 0;
        chk("under_cleared", underrun, 0);
        en = 0; flush = 1; step(1); flush = 0;

        // Overflow: fifth word dropped.
        for (int i = 1; i <= 5; i++) begin
            push_word(DW'(10'h100 + i));
            if (i == 4) begin
                chk("full_at4", full, 1);
                chk("level_at4", level, 4);
            end
        end
        chk("overflow_set", overflow, 1);
        en = 1; step(25);
        chk("no_fifth_word", dac_data, {conv(10'h104), conv(10'h103)});
        chk("drained", level, 0);
        en = 0; flags_clr = 1; step(1); flags_clr = 0;

        // Low watermark and push+pop in the same cycle.
        fifo_threshold = 3'd3; flush = 1; step(1); flush = 0;
        chk("low_l0", low, 1);
        push_word(10'h1A1); chk("low_l1", low, 1);
        push_word(10'h1A2); chk("low_l2", low, 1);
        push_word(10'h1A3); chk("low_l3", low, 0);
        en = 1;
        wait_phase(0, CH, "wait_rd_wrpop");
        lvl0 = m_q.size();
        wr = 1; data = 10'h1A4; step(1); chk("lvl_wrpop1", level, lvl0);
        data = 10'h1A5;         step(1); chk("lvl_wrpop2", level, lvl0);
        wr = 0; step(3);
        en = 0; flush = 1; step(1); flush = 0;

        // Flush in the cycle after the first pop aborts the frame.
        prev = m_dac;
        push_word(10'h0A1); push_word(10'h0A2);
        en = 1;
        wait_phase(0, 1, "wait_rd_flush");
        flush = 1; step(1); flush = 0;
        chk("flush_level", level, 0);
        step(4);
        chk("flush_hold", dac_data, prev);
        en = 0; step(1);
        push_word(10'h0B1); push_word(10'h0B2);
        en = 1;
        wait_phase(1, 0, "wait_ld_realign");
        chk("realigned", dac_data, {conv(10'h0B2), conv(10'h0B1)});

        // Asynchronous reset in the middle of a read.
        en = 0; step(1);
        push_word(10'h0C1); push_word(10'h0C2);
        en = 1;
        wait_phase(0, 1, "wait_rd_reset");
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #1 rst_n = 1'b1;
        en = 0; step(1);

        // Sign-bit handling of extreme codes.
        push_word(10'h3FF); push_word(10'h200);
        en = 1;
        wait_phase(1, 0, "wait_ld_codes");
        chk("code_conv", dac_data, {conv(10'h200), conv(10'h3FF)});

        // Random traffic.
        for (int r = 0; r < 3; r++) begin
            en = 0; flush = 1; step(1); flush = 0;
            clkdiv         = CLKDIV_W'($urandom_range(CH + 1, 12));
            fifo_threshold = 3'($urandom_range(0, 4));
            for (int c = 0; c < 200; c++) begin
                wr        = 1'($urandom_range(0, 1));
                data      = DW'($urandom_range(0, 1023));
                flags_clr = ($urandom_range(0, 15) == 0);
                flush     = ($urandom_range(0, 39) == 0);
                en        = ($urandom_range(0, 19) != 0);
                clk_en    = ($urandom_range(0, 7) != 0);
                step(1);
            end
            wr = 0; flags_clr = 0; flush = 0; clk_en = 1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
